// File: rtl/inst_sram_resp_pkg.sv
// Shared constants and access classification for the instruction-SRAM responder.
package inst_sram_resp_pkg;

  localparam logic [31:0] INST_BASE_ADDR   = 32'h1c000000;
  localparam int          INST_SRAM_ADDR_W = 14;
  localparam int          INST_SRAM_ERR_W  = 16;

  // What the single bank port does in a given cycle.
  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE,
    ACC_OOR,
    ACC_LOAD
  } acc_kind_e;

endpackage

// File: rtl/inst_sram_resp_bank.sv
// Single-port 2^ADDR_W x 32 store with byte enables and a read-first registered output.
module sram_bank_be #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // One byte-wide array per lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
      if (re) begin
        lane_q_reg <= lane_mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = lane_q_reg;
  end

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: CPU port with 1-cycle reads, lower-priority loader port,
// out-of-range detection with sticky error flag and saturating counter.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = INST_BASE_ADDR,
  parameter int          ADDR_W    = INST_SRAM_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_sram_en,
  input  logic [3:0]                 inst_sram_wen,
  input  logic [31:0]                inst_sram_addr,
  input  logic [31:0]                inst_sram_wdata,
  output logic [31:0]                inst_sram_rdata,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [31:0]                ld_addr,
  input  logic [31:0]                ld_data,
  output logic                       err,
  output logic [INST_SRAM_ERR_W-1:0] err_cnt
);

  logic [31:0]       cpu_off;
  logic [31:0]       ld_off;
  logic              cpu_in_range;
  logic              ld_in_range;
  logic              unused_bits;
  acc_kind_e         acc;
  logic              bank_re;
  logic [3:0]        bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata;
  logic              zero_reg;
  logic              err_reg;
  logic [INST_SRAM_ERR_W-1:0] err_cnt_reg;

  assign cpu_off      = inst_sram_addr - BASE_ADDR;
  assign ld_off       = ld_addr - BASE_ADDR;
  assign cpu_in_range = (inst_sram_addr >= BASE_ADDR) && (cpu_off[31:ADDR_W+2] == '0);
  assign ld_in_range  = (ld_addr >= BASE_ADDR) && (ld_off[31:ADDR_W+2] == '0);
  assign unused_bits  = ^{cpu_off[1:0], ld_off[1:0]};

  // The CPU owns the port whenever en is high; nothing is accepted during reset.
  assign ld_ready = ld_valid & ~inst_sram_en & ~reset;

  always_comb begin
    acc = ACC_IDLE;
    if (!reset) begin
      if (inst_sram_en) begin
        if (!cpu_in_range)            acc = ACC_OOR;
        else if (inst_sram_wen != '0) acc = ACC_WRITE;
        else                          acc = ACC_READ;
      end else if (ld_valid && ld_in_range) begin
        acc = ACC_LOAD;
      end
    end
  end

  always_comb begin
    bank_re    = (acc == ACC_READ) || (acc == ACC_WRITE);
    bank_we    = 4'h0;
    bank_addr  = inst_sram_en ? cpu_off[ADDR_W+1:2] : ld_off[ADDR_W+1:2];
    bank_wdata = inst_sram_en ? inst_sram_wdata : ld_data;
    if (acc == ACC_WRITE)     bank_we = inst_sram_wen;
    else if (acc == ACC_LOAD) bank_we = 4'hf;
  end

  sram_bank_be #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (clk),
    .re   (bank_re),
    .we   (bank_we),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

  // zero_reg masks the bank output after reset or an out-of-range access; it
  // and the bank register both hold when en is low, so rdata holds too.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_reg    <= 1'b1;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else if (inst_sram_en) begin
      zero_reg <= ~cpu_in_range;
      if (acc == ACC_OOR) begin
        err_reg <= 1'b1;
        if (err_cnt_reg != '1) begin
          err_cnt_reg <= err_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign inst_sram_rdata = zero_reg ? 32'h0 : bank_rdata;
  assign err             = err_reg;
  assign err_cnt         = err_cnt_reg;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed self-checking bench for inst_sram_resp.
module tb_inst_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        err;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_sram_resp dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .err            (err),
    .err_cnt        (err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cpu(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata);
    inst_sram_en    = en;
    inst_sram_wen   = wen;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
  endtask

  initial begin
    reset = 1'b1;
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    ld_valid = 1'b1;
    ld_addr  = 32'h1c000000;
    ld_data  = 32'h0;
    #1;
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'h0);
    tick();
    tick();
    ld_valid = 1'b0;
    reset    = 1'b0;
    chk("rst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_err_cnt", {16'b0, err_cnt}, 32'h0);

    // Loader fill, then back-to-back reads.
    ld_valid = 1'b1; ld_addr = 32'h1c000000; ld_data = 32'h02800421;
    #1;
    chk("ld_ready_idle", {31'b0, ld_ready}, 32'h1);
    tick();
    ld_addr = 32'h1c000004; ld_data = 32'h02800842;
    tick();
    ld_valid = 1'b0;
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    tick();
    chk("rd_word0", inst_sram_rdata, 32'h02800421);
    cpu(1'b1, 4'h0, 32'h1c000004, 32'h0);
    tick();
    chk("rd_word1", inst_sram_rdata, 32'h02800842);

    // Byte-enable write, read-first, write-then-read.
    cpu(1'b1, 4'hf, 32'h1c000008, 32'h11223344);
    tick();
    cpu(1'b1, 4'b0101, 32'h1c000008, 32'hAABBCCDD);
    tick();
    chk("read_first", inst_sram_rdata, 32'h11223344);
    cpu(1'b1, 4'h0, 32'h1c000008, 32'h0);
    tick();
    chk("byte_merge", inst_sram_rdata, 32'h11BB33DD);

    // CPU priority over loader.
    ld_valid = 1'b1; ld_addr = 32'h1c000008; ld_data = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_stall", {31'b0, ld_ready}, 32'h0);
      tick();
      chk("stall_store", inst_sram_rdata, 32'h11BB33DD);
    end
    cpu(1'b0, 4'h0, 32'h1c000008, 32'h0);
    #1;
    chk("ld_release", {31'b0, ld_ready}, 32'h1);
    tick();
    ld_valid = 1'b0;
    cpu(1'b1, 4'h0, 32'h1c000008, 32'h0);
    tick();
    chk("ld_landed", inst_sram_rdata, 32'hCAFEF00D);

    // Last in-range word.
    cpu(1'b1, 4'hf, 32'h1c00fffc, 32'h5A5A1234);
    tick();
    cpu(1'b1, 4'h0, 32'h1c00fffc, 32'h0);
    tick();
    chk("last_word", inst_sram_rdata, 32'h5A5A1234);

    // Out-of-range on both sides of the window.
    cpu(1'b1, 4'h0, 32'h1bfffffc, 32'h0);
    tick();
    chk("oor_low_rd", inst_sram_rdata, 32'h0);
    chk("oor_low_err", {31'b0, err}, 32'h1);
    chk("oor_low_cnt", {16'b0, err_cnt}, 32'h1);
    cpu(1'b1, 4'hf, 32'h1c010000, 32'hFFFFFFFF);
    tick();
    chk("oor_high_rd", inst_sram_rdata, 32'h0);
    chk("oor_high_cnt", {16'b0, err_cnt}, 32'h2);
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    ld_valid = 1'b1; ld_addr = 32'h1c010000; ld_data = 32'h12345678;
    tick();
    ld_valid = 1'b0;
    chk("ld_oor_cnt", {16'b0, err_cnt}, 32'h2);

    // Reset with a write in flight: write ignored, flags cleared, store kept.
    reset = 1'b1;
    cpu(1'b1, 4'hf, 32'h1c000000, 32'h0);
    tick();
    chk("rst2_rdata", inst_sram_rdata, 32'h0);
    chk("rst2_err", {31'b0, err}, 32'h0);
    chk("rst2_cnt", {16'b0, err_cnt}, 32'h0);
    reset = 1'b0;
    cpu(1'b1, 4'h0, 32'h1c000000, 32'h0);
    tick();
    chk("post_rst_rd", inst_sram_rdata, 32'h02800421);

    // rdata holds while en is low.
    cpu(1'b1, 4'hf, 32'h1c000014, 32'hDEADBEEF);
    tick();
    cpu(1'b1, 4'h0, 32'h1c000014, 32'h0);
    tick();
    chk("rd_mem5", inst_sram_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      cpu(1'b0, 4'h0, 32'h1c000000 + 32'(i * 4), 32'h0);
      tick();
      chk("hold_rdata", inst_sram_rdata, 32'hDEADBEEF);
    end

    // Saturation of the error counter.
    force dut.err_cnt_reg = 16'hfffe;
    #2;
    release dut.err_cnt_reg;
    for (int i = 0; i < 3; i++) begin
      cpu(1'b1, 4'h0, 32'h00000000, 32'h0);
      tick();
      chk("sat_cnt", {16'b0, err_cnt}, 32'h0000ffff);
    end
    cpu(1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
